// File: rtl/gcd_stim_pkg.sv
// Shared types and helpers for the gcd miter stimulus generator.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package gcd_stim_pkg;

  // Default operand width; the LFSR is twice this wide.
  localparam int DEF_WIDTH = 6;

  // Campaign sequencer states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } stim_state_t;

  // Fibonacci tap masks (bit i set = l[i] feeds the XOR). The 12-bit
  // mask gives l[11]^l[5]^l[3]^l[0].
  localparam logic [31:0] TAPS_4  = 32'h0000_000C;
  localparam logic [31:0] TAPS_8  = 32'h0000_00B8;
  localparam logic [31:0] TAPS_10 = 32'h0000_0240;
  localparam logic [31:0] TAPS_12 = 32'h0000_0829;
  localparam logic [31:0] TAPS_16 = 32'h0000_D008;

  // Pick a tap mask for an n-bit register; other sizes fall back to the
  // two top bits, which still shifts but may not be maximal length.
  function automatic logic [31:0] lfsr_taps(input int n);
    logic [31:0] m;
    case (n)
      4:       m = TAPS_4;
      8:       m = TAPS_8;
      10:      m = TAPS_10;
      12:      m = TAPS_12;
      16:      m = TAPS_16;
      default: m = (32'h1 << (n - 1)) | (32'h1 << (n - 2));
    endcase
    return m;
  endfunction

  // A zero operand would keep the GCD engine spinning forever, so the
  // low w bits of v are replaced by 1 when they are all zero.
  function automatic logic [31:0] nz_operand(input logic [31:0] v, input int w);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    return ((v & mask) == 32'h0) ? 32'h1 : (v & mask);
  endfunction

endpackage

// File: rtl/gcd_stim_lfsr.sv
// Seedable Fibonacci LFSR feeding the operand pair of each vector.
// Latency: state changes on the clock edge after load or step is high.
// Backpressure: holds its value whenever neither load nor step is asserted.
module gcd_stim_lfsr
  import gcd_stim_pkg::*;
#(
  parameter int           N    = 12,
  parameter logic [N-1:0] SEED = 12'hACE
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic         i_step,
  output logic [N-1:0] o_state
);

  // All-zero is the lock-up state of an XOR LFSR, so a zero seed becomes 1.
  localparam logic [N-1:0] SEED_NZ = (SEED == '0) ? N'(1) : SEED;
  localparam logic [N-1:0] TAPS    = N'(lfsr_taps(N));

  logic [N-1:0] r_lfsr;
  logic         w_fb;

  assign w_fb    = ^(r_lfsr & TAPS);
  assign o_state = r_lfsr;

  // Reload the seed on load, otherwise shift the feedback in at the LSB.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr <= SEED_NZ;
    end else if (i_load) begin
      r_lfsr <= SEED_NZ;
    end else if (i_step) begin
      r_lfsr <= {r_lfsr[N-2:0], w_fb};
    end
  end

endmodule

// File: rtl/gcd_stim_gen.sv
// Campaign sequencer: launches LFSR operand pairs at the gcd miter and tallies equiv.
// Latency: start/busy/done are registered one edge behind the state; NUM_VECTORS*(SETTLE_CYCLES+2)+1 edges to done.
// Backpressure: run low aborts to IDLE at the next edge; STOP_ON_FAIL_EN ends the campaign at the first failing vector.
module gcd_stim_gen
  import gcd_stim_pkg::*;
#(
  parameter int                 WIDTH         = DEF_WIDTH,
  parameter int                 SETTLE_CYCLES = 16,
  parameter int                 NUM_VECTORS   = 64,
  parameter logic [2*WIDTH-1:0] LFSR_SEED     = 12'hACE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  output logic             start,
  output logic [WIDTH-1:0] Ain,
  output logic [WIDTH-1:0] Bin,
  input  logic             equiv,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [7:0]       pass_count,
  output logic [7:0]       fail_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b
);

  localparam int         LW       = 2 * WIDTH;
  localparam logic [7:0] SETTLE_L = 8'(SETTLE_CYCLES);
  localparam logic [7:0] LAST_IDX = 8'(NUM_VECTORS - 1);

  stim_state_t      r_state;
  logic             r_start;
  logic             r_busy;
  logic             r_done;
  logic             r_fail;
  logic [WIDTH-1:0] r_ain;
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_fail_a;
  logic [WIDTH-1:0] r_fail_b;
  logic [7:0]       r_pass_cnt;
  logic [7:0]       r_fail_cnt;
  logic [7:0]       r_wait_cnt;
  logic [7:0]       r_idx;
  logic             r_vec_err;

  logic [LW-1:0]    w_lfsr;
  logic             w_lfsr_load;
  logic             w_lfsr_step;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic             w_chk_err;
  logic             w_active;

  // Seed reload happens as the campaign starts; one step per checked vector.
  assign w_lfsr_load = (r_state == IDLE) && run;
  assign w_lfsr_step = (r_state == CHECK) && run;

  gcd_stim_lfsr #(
    .N    (LW),
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_lfsr_load),
    .i_step  (w_lfsr_step),
    .o_state (w_lfsr)
  );

  // Upper half is A, lower half is B, each forced non-zero.
  assign w_op_a = WIDTH'(nz_operand(32'(w_lfsr[LW-1:WIDTH]), WIDTH));
  assign w_op_b = WIDTH'(nz_operand(32'(w_lfsr[WIDTH-1:0]), WIDTH));

  // equiv is still observed during CHECK, so fold it into the vector verdict.
  assign w_chk_err = r_vec_err | ~equiv;
  assign w_active  = (r_state == LAUNCH) || (r_state == WAIT) || (r_state == CHECK);

  // Sequencer with registered outputs; leaving run low from any busy
  // state abandons the current vector without counting it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_fail     <= 1'b0;
      r_ain      <= '0;
      r_bin      <= '0;
      r_fail_a   <= '0;
      r_fail_b   <= '0;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_wait_cnt <= '0;
      r_idx      <= '0;
      r_vec_err  <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_busy  <= run && w_active;
      r_done  <= run && (r_state == DONE);
      case (r_state)
        IDLE: begin
          if (run) begin
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_fail     <= 1'b0;
            r_fail_a   <= '0;
            r_fail_b   <= '0;
            r_idx      <= '0;
            r_state    <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (!run) begin
            r_state <= IDLE;
          end else begin
            r_start    <= 1'b1;
            r_ain      <= w_op_a;
            r_bin      <= w_op_b;
            r_vec_err  <= 1'b0;
            r_wait_cnt <= SETTLE_L;
            r_state    <= WAIT;
          end
        end
        WAIT: begin
          if (!run) begin
            r_state <= IDLE;
          end else begin
            if (!equiv) begin
              r_vec_err <= 1'b1;
            end
            r_wait_cnt <= r_wait_cnt - 8'd1;
            if (r_wait_cnt <= 8'd1) begin
              r_state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (!run) begin
            r_state <= IDLE;
          end else begin
            if (w_chk_err) begin
              r_fail_cnt <= r_fail_cnt + 8'd1;
              r_fail     <= 1'b1;
              if (!r_fail) begin
                r_fail_a <= r_ain;
                r_fail_b <= r_bin;
              end
            end else begin
              r_pass_cnt <= r_pass_cnt + 8'd1;
            end
            r_idx <= r_idx + 8'd1;
`ifdef STOP_ON_FAIL_EN
            if ((r_idx == LAST_IDX) || w_chk_err) begin
`else
            if (r_idx == LAST_IDX) begin
`endif
              r_state <= DONE;
            end else begin
              r_state <= LAUNCH;
            end
          end
        end
        DONE: begin
          if (!run) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign start      = r_start;
  assign busy       = r_busy;
  assign done       = r_done;
  assign fail       = r_fail;
  assign Ain        = r_ain;
  assign Bin        = r_bin;
  assign fail_a     = r_fail_a;
  assign fail_b     = r_fail_b;
  assign pass_count = r_pass_cnt;
  assign fail_count = r_fail_cnt;

endmodule

// File: tb/tb_gcd_stim_gen.sv
// Directed bench for gcd_stim_gen with NUM_VECTORS=4, SETTLE_CYCLES=3.
// Latency: expectations are written against edge numbers counted from the edge that first samples run high.
// Backpressure: equiv and run are driven directly to exercise error and abort paths.
module tb_gcd_stim_gen;

  localparam int W  = 6;
  localparam int NV = 4;
  localparam int SC = 3;

  logic         clk;
  logic         reset_n;
  logic         run;
  logic         equiv;
  logic         start;
  logic [W-1:0] Ain;
  logic [W-1:0] Bin;
  logic         busy;
  logic         done;
  logic         fail;
  logic [7:0]   pass_count;
  logic [7:0]   fail_count;
  logic [W-1:0] fail_a;
  logic [W-1:0] fail_b;

  int n_checks;
  int n_fail;

  gcd_stim_gen #(
    .WIDTH         (W),
    .SETTLE_CYCLES (SC),
    .NUM_VECTORS   (NV),
    .LFSR_SEED     (12'hACE)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (run),
    .start      (start),
    .Ain        (Ain),
    .Bin        (Bin),
    .equiv      (equiv),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .pass_count (pass_count),
    .fail_count (fail_count),
    .fail_a     (fail_a),
    .fail_b     (fail_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Vector operands from seed 12'hACE: 0xACE, 0x59C, 0xB39, 0x672.
  localparam logic [W-1:0] A0 = 6'd43, B0 = 6'd14;
  localparam logic [W-1:0] A1 = 6'd22, B1 = 6'd28;
  localparam logic [W-1:0] A2 = 6'd44, B2 = 6'd57;

`ifdef STOP_ON_FAIL_EN
  localparam int STOP = 1;
`else
  localparam int STOP = 0;
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    run      = 1'b0;
    equiv    = 1'b1;
    #12;
    reset_n  = 1'b1;

    // Reset state
    check_eq("rst_start", 32'(start), 0);
    check_eq("rst_busy",  32'(busy), 0);
    check_eq("rst_done",  32'(done), 0);
    check_eq("rst_fail",  32'(fail), 0);
    check_eq("rst_ab",    32'({Ain, Bin}), 0);
    check_eq("rst_cnts",  32'({pass_count, fail_count}), 0);

    // Golden campaign
    run = 1'b1;
    tick();  // edge 0
    check_eq("e0_start", 32'(start), 0);
    tick();  // edge 1
    check_eq("e1_start", 32'(start), 1);
    check_eq("v0_a", 32'(Ain), 32'(A0));
    check_eq("v0_b", 32'(Bin), 32'(B0));
    tick();  // edge 2
    check_eq("e2_start", 32'(start), 0);
    check_eq("e2_busy",  32'(busy), 1);
    check_eq("e2_hold_a", 32'(Ain), 32'(A0));
    ticks(4);  // edges 3..6
    check_eq("e6_start", 32'(start), 1);
    check_eq("v1_a", 32'(Ain), 32'(A1));
    check_eq("v1_b", 32'(Bin), 32'(B1));
    ticks(14);  // edges 7..20
    check_eq("e20_done", 32'(done), 0);
    tick();  // edge 21
    check_eq("e21_done", 32'(done), 1);
    check_eq("e21_busy", 32'(busy), 0);
    check_eq("gold_pass", 32'(pass_count), NV);
    check_eq("gold_failc", 32'(fail_count), 0);
    check_eq("gold_fail", 32'(fail), 0);
    run = 1'b0;
    tick();
    check_eq("done_clear", 32'(done), 0);

    // One-cycle equiv drop in WAIT of vector 2 (sampled at edge 13)
    run = 1'b1;
    ticks(13);  // edges 0..12
    equiv = 1'b0;
    tick();     // edge 13
    equiv = 1'b1;
    ticks(8);   // edges 14..21
    check_eq("v2_done", 32'(done), 1);
    check_eq("v2_pass", 32'(pass_count), (STOP != 0) ? 2 : 3);
    check_eq("v2_failc", 32'(fail_count), 1);
    check_eq("v2_fail", 32'(fail), 1);
    check_eq("v2_fail_a", 32'(fail_a), 32'(A2));
    check_eq("v2_fail_b", 32'(fail_b), 32'(B2));
    run = 1'b0;
    tick();

    // Abort during WAIT of vector 1, then restart
    run = 1'b1;
    ticks(8);   // edges 0..7
    run = 1'b0;
    tick();     // edge 8: back in IDLE
    check_eq("ab_start", 32'(start), 0);
    check_eq("ab_busy", 32'(busy), 0);
    check_eq("ab_pass", 32'(pass_count), 1);
    check_eq("ab_failc", 32'(fail_count), 0);
    tick();
    check_eq("ab_hold", 32'(pass_count), 1);
    run = 1'b1;
    tick();     // edge 0
    check_eq("re_clear", 32'(pass_count), 0);
    tick();     // edge 1
    check_eq("re_start", 32'(start), 1);
    check_eq("re_a", 32'(Ain), 32'(A0));
    check_eq("re_b", 32'(Bin), 32'(B0));
    ticks(7);   // edges 2..8
    check_eq("pre_rst_pass", 32'(pass_count), 1);

    // Asynchronous reset between edges
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy), 0);
    check_eq("arst_ab", 32'({Ain, Bin}), 0);
    check_eq("arst_pass", 32'(pass_count), 0);
    check_eq("arst_start", 32'(start), 0);
    run = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
    check_eq("arst_idle", 32'(busy), 0);

    // Failure on vector 0: stop early or run to the end
    run   = 1'b1;
    equiv = 1'b0;
    ticks(4);   // edges 0..3
    equiv = 1'b1;
    ticks(3);   // edges 4..6
    check_eq("sf_done_e6", 32'(done), (STOP != 0) ? 1 : 0);
    ticks(15);  // edges 7..21
    check_eq("sf_done", 32'(done), 1);
    check_eq("sf_pass", 32'(pass_count), (STOP != 0) ? 0 : 3);
    check_eq("sf_failc", 32'(fail_count), 1);
    check_eq("sf_fail_a", 32'(fail_a), 32'(A0));
    check_eq("sf_fail_b", 32'(fail_b), 32'(B0));
    run = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
